text_buffer_ctrl: RTL and testbench
===================================

# text_buffer_ctrl

Sequencer and write-port arbiter in front of the 80x25 character buffer. Accepts key codes over a valid/ready handshake, interprets printable and control characters, tracks the cursor, and sweeps fill characters through the buffer for screen clears. It is the only writer of the character buffer and drives its cursor and write-strobe inputs.

## Interface
- COLS, 80, columns per row (≤128)
- ROWS, 25, rows per screen (≤32)
- FILL, 8'h20, character written by clears and backspace
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- key_valid  in  1  key_code offered
- key_ready  out  1  controller can accept a key this cycle
- key_code  in  8  ASCII code
- clear_req  in  1  level; request full-screen clear
- wr_en  out  1  buffer write strobe, one cycle per cell
- wr_x  out  7  write column
- wr_y  out  5  write row
- wr_data  out  8  write character
- cursor_x  out  7  current cursor column
- cursor_y  out  5  current cursor row
- busy  out  1  state ≠ IDLE

## Operation
- States: CLEAR_ALL, IDLE, CLEAR_LINE.
- Reset: state=CLEAR_ALL, sweep counter 0, cursor (0,0), wr_en=0, wr_x=0, wr_y=0, wr_data=FILL, busy=1, key_ready=0.
- CLEAR_ALL: one FILL write per cycle, row-major (x inner, y outer), (0,0) to (COLS-1,ROWS-1); cursor forced to (0,0); on the edge presenting the last cell → IDLE.
- IDLE: key_ready = !clear_req. clear_req high → CLEAR_ALL (wins over a simultaneous key_valid; key not accepted). clear_req in CLEAR_ALL/CLEAR_LINE ignored.
- Accepted key (key_valid & key_ready):
  - 0x20–0x7E: write code at cursor; advance x; x==COLS-1 → x=0, y+1 (autowrap).
  - 0x0A or 0x0D: x=0, y+1; no write.
  - 0x08: x>0 → x-1; x==0, y>0 → x=COLS-1, y-1; at (0,0) cursor holds. Writes FILL at the new position; no write at (0,0).
  - 0x0C: → CLEAR_ALL.
  - Any other code: consumed, no effect.
- Row advance: y==ROWS-1 → y=0 (wrap, no scroll).
- CLEAR_LINE (only with macro): entered on any row advance (newline or autowrap); writes FILL to x=0..COLS-1 of the new row, then → IDLE. cursor_x stays 0 during sweep.

## Timing
- All outputs registered except key_ready (combinational from state and clear_req).
- Key accepted at edge N: wr_en/wr_x/wr_y/wr_data and cursor update at edge N; wr_en is high for exactly the cycle after N.
- Printable, control and backspace keys: 1 cycle each; back-to-back acceptance every cycle in IDLE.
- CLEAR_ALL: exactly COLS*ROWS write cycles; key_ready high in the cycle the last write is presented.
- CLEAR_LINE: exactly COLS write cycles after the triggering key cycle.
- wr_en low in every cycle with no write; wr_x/wr_y/wr_data hold their last values.
- Reset mid-sweep: sweep aborted; after release, CLEAR_ALL restarts from (0,0).

## Configuration
- TEXT_BUFFER_CTRL_LINE_CLEAR_EN defined: row advance enters CLEAR_LINE; new line is blank before typing resumes.
- Undefined: CLEAR_LINE state and logic absent; row advance is a 1-cycle cursor update; old text is overwritten in place.

## Structure
- Package text_ctrl_pkg: state enum, ASCII constants (ASCII_BS=8'h08, ASCII_LF=8'h0A, ASCII_FF=8'h0C, ASCII_CR=8'h0D, ASCII_SPACE=8'h20, printable range bounds).
- Sub-module text_clear_sweep: x/y sweep counter with start, full-screen/single-row mode, done pulse; shared by CLEAR_ALL and CLEAR_LINE.

## Test plan
- Reset release → exactly 2000 FILL writes, (0,0) to (79,24) row-major; key_ready rises in the cycle the (79,24) write is presented; cursor (0,0).
- Keys 'H'(0x48), 'i'(0x69) back-to-back → writes (0,0)=0x48, (1,0)=0x69 on consecutive cycles; cursor (2,0).
- Cursor (79,24), key 0x41 → write (79,24)=0x41; cursor (0,0); with macro, 80 FILL writes on row 0 and key_ready low for 80 cycles.
- Backspace at (0,3) → FILL write at (79,2), cursor (79,2); backspace at (0,0) → no write, cursor holds.
- clear_req and key_valid (0x41) in the same IDLE cycle → key not accepted, 2000-cell clear, then 0x41 is accepted and written at (0,0).
- Reset asserted mid-CLEAR_ALL at cell 500 → outputs take reset values; after release, sweep restarts at (0,0) and completes 2000 writes.

Source files
------------

// File: rtl/text_ctrl_pkg.sv
// Shared types and constants for the text buffer controller.
// TEXT_BUFFER_CTRL_LINE_CLEAR_EN adds the CLEAR_LINE state.
package text_ctrl_pkg;

  localparam int unsigned X_W = 7;
  localparam int unsigned Y_W = 5;

  localparam logic [7:0] ASCII_BS       = 8'h08;
  localparam logic [7:0] ASCII_LF       = 8'h0A;
  localparam logic [7:0] ASCII_FF       = 8'h0C;
  localparam logic [7:0] ASCII_CR       = 8'h0D;
  localparam logic [7:0] ASCII_SPACE    = 8'h20;
  localparam logic [7:0] ASCII_PRINT_LO = 8'h20;
  localparam logic [7:0] ASCII_PRINT_HI = 8'h7E;

`ifdef TEXT_BUFFER_CTRL_LINE_CLEAR_EN
  typedef enum logic [1:0] {
    CLEAR_ALL  = 2'd0,
    IDLE       = 2'd1,
    CLEAR_LINE = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    CLEAR_ALL = 2'd0,
    IDLE      = 2'd1
  } state_t;
`endif

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= ASCII_PRINT_LO) && (c <= ASCII_PRINT_HI);
  endfunction

  // Row advance wraps to the top; there is no scrolling.
  function automatic logic [Y_W-1:0] row_inc(input logic [Y_W-1:0] y,
                                             input int unsigned rows);
    return (32'(y) == rows - 1) ? '0 : y + 1'b1;
  endfunction

endpackage

// File: rtl/text_buffer_ctrl_if.sv
// Key handshake, write port and status signals of the text buffer controller.
interface text_buffer_ctrl_if;
  import text_ctrl_pkg::*;

  logic           key_valid;
  logic           key_ready;
  logic [7:0]     key_code;
  logic           clear_req;
  logic           wr_en;
  logic [X_W-1:0] wr_x;
  logic [Y_W-1:0] wr_y;
  logic [7:0]     wr_data;
  logic [X_W-1:0] cursor_x;
  logic [Y_W-1:0] cursor_y;
  logic           busy;

  modport master (
    output key_valid, key_code, clear_req,
    input  key_ready, wr_en, wr_x, wr_y, wr_data, cursor_x, cursor_y, busy
  );

  modport slave (
    input  key_valid, key_code, clear_req,
    output key_ready, wr_en, wr_x, wr_y, wr_data, cursor_x, cursor_y, busy
  );
endinterface

// File: rtl/text_clear_sweep.sv
// x/y cell sweep counter shared by full-screen and single-row clears.
module text_clear_sweep
  import text_ctrl_pkg::*;
#(
  parameter int unsigned COLS = 80,
  parameter int unsigned ROWS = 25
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic [Y_W-1:0] load_y,
  input  logic           advance,
  input  logic           full,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           done
);

  localparam logic [X_W-1:0] X_LAST = X_W'(COLS - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(ROWS - 1);

  logic x_last;
  logic y_last;

  assign x_last = (x == X_LAST);
  assign y_last = (y == Y_LAST);
  assign done   = advance && x_last && (y_last || !full);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (load) begin
      x <= '0;
      y <= load_y;
    end else if (advance) begin
      if (x_last) begin
        x <= '0;
        y <= y_last ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/text_buffer_ctrl.sv
// Key sequencer and sole write-port driver for the 80x25 character buffer.
// TEXT_BUFFER_CTRL_LINE_CLEAR_EN: blank each new row on a row advance.
module text_buffer_ctrl
  import text_ctrl_pkg::*;
#(
  parameter int unsigned COLS = 80,
  parameter int unsigned ROWS = 25,
  parameter logic [7:0]  FILL = 8'h20
) (
  input  logic               clk,
  input  logic               reset,
  text_buffer_ctrl_if.slave  bus
);

  localparam logic [X_W-1:0] X_LAST = X_W'(COLS - 1);

  state_t         state, state_n;
  logic [X_W-1:0] cur_x, cur_x_n;
  logic [Y_W-1:0] cur_y, cur_y_n;
  logic           wr_en_q, wr_en_n;
  logic [X_W-1:0] wr_x_q, wr_x_n;
  logic [Y_W-1:0] wr_y_q, wr_y_n;
  logic [7:0]     wr_data_q, wr_data_n;

  logic           sw_load;
  logic [Y_W-1:0] sw_load_y;
  logic           sw_adv;
  logic           sw_full;
  logic [X_W-1:0] sw_x;
  logic [Y_W-1:0] sw_y;
  logic           sw_done;

`ifdef TEXT_BUFFER_CTRL_LINE_CLEAR_EN
  logic           row_adv;
`endif

  assign sw_full = (state == CLEAR_ALL);

  text_clear_sweep #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_sweep (
    .clk     (clk),
    .reset   (reset),
    .load    (sw_load),
    .load_y  (sw_load_y),
    .advance (sw_adv),
    .full    (sw_full),
    .x       (sw_x),
    .y       (sw_y),
    .done    (sw_done)
  );

  assign bus.key_ready = (state == IDLE) && !bus.clear_req;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_x      = wr_x_q;
  assign bus.wr_y      = wr_y_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.cursor_x  = cur_x;
  assign bus.cursor_y  = cur_y;
  assign bus.busy      = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= CLEAR_ALL;
      cur_x     <= '0;
      cur_y     <= '0;
      wr_en_q   <= 1'b0;
      wr_x_q    <= '0;
      wr_y_q    <= '0;
      wr_data_q <= FILL;
    end else begin
      state     <= state_n;
      cur_x     <= cur_x_n;
      cur_y     <= cur_y_n;
      wr_en_q   <= wr_en_n;
      wr_x_q    <= wr_x_n;
      wr_y_q    <= wr_y_n;
      wr_data_q <= wr_data_n;
    end
  end

  always_comb begin
    state_n   = state;
    cur_x_n   = cur_x;
    cur_y_n   = cur_y;
    wr_en_n   = 1'b0;
    wr_x_n    = wr_x_q;
    wr_y_n    = wr_y_q;
    wr_data_n = wr_data_q;
    sw_load   = 1'b0;
    sw_load_y = '0;
    sw_adv    = 1'b0;
`ifdef TEXT_BUFFER_CTRL_LINE_CLEAR_EN
    row_adv   = 1'b0;
`endif

    case (state)
      CLEAR_ALL: begin
        sw_adv    = 1'b1;
        wr_en_n   = 1'b1;
        wr_x_n    = sw_x;
        wr_y_n    = sw_y;
        wr_data_n = FILL;
        cur_x_n   = '0;
        cur_y_n   = '0;
        if (sw_done) state_n = IDLE;
      end

      IDLE: begin
        if (bus.clear_req) begin
          state_n = CLEAR_ALL;
          sw_load = 1'b1;
          cur_x_n = '0;
          cur_y_n = '0;
        end else if (bus.key_valid) begin
          if (is_printable(bus.key_code)) begin
            wr_en_n   = 1'b1;
            wr_x_n    = cur_x;
            wr_y_n    = cur_y;
            wr_data_n = bus.key_code;
            if (cur_x == X_LAST) begin
              cur_x_n = '0;
              cur_y_n = row_inc(cur_y, ROWS);
`ifdef TEXT_BUFFER_CTRL_LINE_CLEAR_EN
              row_adv = 1'b1;
`endif
            end else begin
              cur_x_n = cur_x + 1'b1;
            end
          end else if (bus.key_code == ASCII_LF || bus.key_code == ASCII_CR) begin
            cur_x_n = '0;
            cur_y_n = row_inc(cur_y, ROWS);
`ifdef TEXT_BUFFER_CTRL_LINE_CLEAR_EN
            row_adv = 1'b1;
`endif
          end else if (bus.key_code == ASCII_BS) begin
            if (cur_x != '0) begin
              cur_x_n   = cur_x - 1'b1;
              wr_en_n   = 1'b1;
              wr_x_n    = cur_x - 1'b1;
              wr_y_n    = cur_y;
              wr_data_n = FILL;
            end else if (cur_y != '0) begin
              cur_x_n   = X_LAST;
              cur_y_n   = cur_y - 1'b1;
              wr_en_n   = 1'b1;
              wr_x_n    = X_LAST;
              wr_y_n    = cur_y - 1'b1;
              wr_data_n = FILL;
            end
          end else if (bus.key_code == ASCII_FF) begin
            state_n = CLEAR_ALL;
            sw_load = 1'b1;
            cur_x_n = '0;
            cur_y_n = '0;
          end
        end
      end

`ifdef TEXT_BUFFER_CTRL_LINE_CLEAR_EN
      CLEAR_LINE: begin
        sw_adv    = 1'b1;
        wr_en_n   = 1'b1;
        wr_x_n    = sw_x;
        wr_y_n    = sw_y;
        wr_data_n = FILL;
        if (sw_done) state_n = IDLE;
      end
`endif

      default: state_n = CLEAR_ALL;
    endcase

`ifdef TEXT_BUFFER_CTRL_LINE_CLEAR_EN
    // The sweep is loaded on the same edge that commits the key's own write.
    if (row_adv) begin
      state_n   = CLEAR_LINE;
      sw_load   = 1'b1;
      sw_load_y = cur_y_n;
    end
`endif
  end

endmodule

// File: tb/tb_text_buffer_ctrl.sv
// Directed and random key traffic against a linear-cursor reference model.
module tb_text_buffer_ctrl;

  localparam int         COLS  = 80;
  localparam int         ROWS  = 25;
  localparam int         NCELL = COLS * ROWS;
  localparam logic [7:0] FILL  = 8'h20;

  logic clk = 1'b0;
  logic reset;

  text_buffer_ctrl_if bus();

  text_buffer_ctrl #(.COLS(COLS), .ROWS(ROWS), .FILL(FILL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         vectors     = 0;
  int         miscompares = 0;
  int         pos;
  int         lw_x, lw_y;
  logic [7:0] lw_d;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_wr_en"}, 32'(bus.wr_en), 0);
    check({tag, "_wr_x"}, 32'(bus.wr_x), 0);
    check({tag, "_wr_y"}, 32'(bus.wr_y), 0);
    check({tag, "_wr_data"}, 32'(bus.wr_data), 32'(FILL));
    check({tag, "_cursor"}, {16'(bus.cursor_x), 16'(bus.cursor_y)}, 0);
    check({tag, "_busy"}, 32'(bus.busy), 1);
    check({tag, "_key_ready"}, 32'(bus.key_ready), 0);
  endtask

  // Waits for a full-screen or single-row sweep and grades it as a whole.
  task automatic sweep_check(input bit full, input int row);
    int total, n, bad;
    total = full ? NCELL : COLS;
    n = 0;
    bad = 0;
    for (int cyc = 0; cyc < total + 4 && n < total; cyc++) begin
      @(posedge clk); #1;
      if (bus.wr_en === 1'b1) begin
        if (bus.wr_x !== 7'(n % COLS) || bus.wr_y !== 5'(full ? n / COLS : row) ||
            bus.wr_data !== FILL) bad++;
        if (bus.key_ready !== (n == total - 1)) bad++;
        if (bus.busy !== (n != total - 1)) bad++;
        if (bus.cursor_x !== 7'd0) bad++;
        if (full && bus.cursor_y !== 5'd0) bad++;
        n++;
      end else begin
        if (n > 0 || bus.key_ready !== 1'b0) bad++;
      end
    end
    check(full ? "clear_all_count" : "clear_line_count", 32'(n), 32'(total));
    check(full ? "clear_all_order" : "clear_line_order", 32'(bad), 0);
    check("sweep_cursor", {16'(bus.cursor_x), 16'(bus.cursor_y)},
          {16'd0, 16'(full ? 0 : row)});
    lw_x = COLS - 1;
    lw_y = full ? ROWS - 1 : row;
    lw_d = FILL;
  endtask

  // One accepted key; the expected effect is computed on a linear cell index.
  task automatic key_step(input logic [7:0] code);
    logic       exp_we, row_adv, do_clear, exp_busy;
    int         wpos;
    logic [7:0] wd;
    exp_we = 1'b0; row_adv = 1'b0; do_clear = 1'b0; wpos = 0; wd = FILL;
    if (code >= 8'h20 && code <= 8'h7E) begin
      exp_we = 1'b1; wpos = pos; wd = code;
      row_adv = (pos % COLS == COLS - 1);
      pos = (pos + 1) % NCELL;
    end else if (code == 8'h0A || code == 8'h0D) begin
      pos = ((pos / COLS + 1) % ROWS) * COLS;
      row_adv = 1'b1;
    end else if (code == 8'h08) begin
      if (pos > 0) begin
        pos--; exp_we = 1'b1; wpos = pos;
      end
    end else if (code == 8'h0C) begin
      do_clear = 1'b1;
      pos = 0;
    end
    exp_busy = do_clear;
`ifdef TEXT_BUFFER_CTRL_LINE_CLEAR_EN
    exp_busy = do_clear | row_adv;
`endif
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    #1;
    check("key_ready", 32'(bus.key_ready), 1);
    @(posedge clk); #1;
    bus.key_valid = 1'b0;
    if (exp_we) begin
      lw_x = wpos % COLS; lw_y = wpos / COLS; lw_d = wd;
    end
    check("key_wr_en", 32'(bus.wr_en), 32'(exp_we));
    check("key_wr_cell", {8'(bus.wr_x), 8'(bus.wr_y), 8'(bus.wr_data)},
          {8'(lw_x), 8'(lw_y), lw_d});
    if (!do_clear)
      check("key_cursor", {16'(bus.cursor_x), 16'(bus.cursor_y)},
            {16'(pos % COLS), 16'(pos / COLS)});
    check("key_busy", 32'(bus.busy), 32'(exp_busy));
    if (do_clear) sweep_check(1'b1, 0);
`ifdef TEXT_BUFFER_CTRL_LINE_CLEAR_EN
    if (row_adv) sweep_check(1'b0, pos / COLS);
`endif
  endtask

  function automatic logic [7:0] rand_key();
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4, 5: return 8'($urandom_range(32, 126));
      6:       return ($urandom_range(0, 1) == 0) ? 8'h0A : 8'h0D;
      7, 8:    return 8'h08;
      default: begin
        case ($urandom_range(0, 2))
          0:       return 8'h7F;
          1:       return 8'($urandom_range(0, 7));
          default: return 8'($urandom_range(128, 255));
        endcase
      end
    endcase
  endfunction

  initial begin
    int n;
    reset         = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_code  = 8'h00;
    bus.clear_req = 1'b0;
    pos  = 0;
    lw_x = 0; lw_y = 0; lw_d = FILL;

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    reset = 1'b0;
    sweep_check(1'b1, 0);

    key_step(8'h48);
    key_step(8'h69);
    check("hi_cursor", {16'(bus.cursor_x), 16'(bus.cursor_y)}, {16'd2, 16'd0});

    repeat (3) key_step(8'h0A);
    key_step(8'h08);
    check("bs_wrap_cell", {8'(bus.wr_x), 8'(bus.wr_y)}, {8'd79, 8'd2});

    key_step(8'h0C);
    key_step(8'h08);
    check("bs_origin_cursor", {16'(bus.cursor_x), 16'(bus.cursor_y)}, 0);

    repeat (ROWS - 1) key_step(8'h0A);
    for (int i = 0; i < COLS - 1; i++) key_step(8'(8'h61 + i % 26));
    check("corner_cursor", {16'(bus.cursor_x), 16'(bus.cursor_y)}, {16'd79, 16'd24});
    key_step(8'h41);

    for (int i = 0; i < 300; i++) key_step(rand_key());

    // clear_req beats a simultaneous key; the key is taken once the clear ends
    bus.clear_req = 1'b1;
    bus.key_valid = 1'b1;
    bus.key_code  = 8'h41;
    #1;
    check("clr_vs_key_ready", 32'(bus.key_ready), 0);
    @(posedge clk); #1;
    bus.clear_req = 1'b0;
    check("clr_vs_key_wr_en", 32'(bus.wr_en), 0);
    check("clr_vs_key_busy", 32'(bus.busy), 1);
    sweep_check(1'b1, 0);
    pos = 0;
    key_step(8'h41);
    check("clr_vs_key_cell", {8'(bus.wr_x), 8'(bus.wr_y), 8'(bus.wr_data)}, {8'd0, 8'd0, 8'h41});

    bus.clear_req = 1'b1;
    @(posedge clk); #1;
    bus.clear_req = 1'b0;
    n = 0;
    for (int cyc = 0; cyc < 600 && n < 500; cyc++) begin
      @(posedge clk); #1;
      if (bus.wr_en === 1'b1) n++;
    end
    check("abort_count", 32'(n), 500);
    reset = 1'b1;
    #1;
    check_reset_vals("abort_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    pos = 0;
    sweep_check(1'b1, 0);
    key_step(8'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
